// File: rtl/leaf_stream_packetizer_if.sv
// User-side ap_vld/ap_ack word handshake between a kernel output stream and the packetizer.
// The kernel holds din/vld until ack is seen; ack is combinational on the packetizer side.
interface leaf_stream_packetizer_if #(
    parameter int PAYLOAD_BITS = 32
);
    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic                    vld_user2interface;
    logic                    ack_interface2user;

    modport master (
        output din_leaf_user2interface,
        output vld_user2interface,
        input  ack_interface2user
    );

    modport slave (
        input  din_leaf_user2interface,
        input  vld_user2interface,
        output ack_interface2user
    );
endinterface

// File: rtl/leaf_stream_packetizer.sv
// Leaf transmit path: wraps user words into BFT packets under credit-based flow control,
// with single-cycle packet pulses and on-demand re-issue of the most recent packet.
module leaf_stream_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                     clk_user,
    input  logic                     reset,
    leaf_stream_packetizer_if.slave  user,
    input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] dst_port,
    input  logic                     freespace_update,
    input  logic                     resend,
    output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
    output logic                     credit_overflow
);
    localparam int CREDIT_W = NUM_ADDR_BITS + 1;
    localparam int SUM_W    = 32;
    localparam logic [SUM_W-1:0] CREDIT_CAP = SUM_W'(1) << NUM_ADDR_BITS;

    typedef enum logic {
        ST_RUN,
        ST_RESEND
    } state_t;

    state_t                   state;
    logic [CREDIT_W-1:0]      credits;
    logic [NUM_ADDR_BITS-1:0] addr_ptr;
    logic [PACKET_BITS-1:0]   last_pkt;
    logic                     last_vld;
    logic                     ack;
    logic [PACKET_BITS-1:0]   new_pkt;
    logic [SUM_W-1:0]         credit_sum;

    function automatic logic credit_sat_ovf(input logic [SUM_W-1:0] sum);
        return sum > CREDIT_CAP;
    endfunction

    function automatic logic [CREDIT_W-1:0] credit_sat(input logic [SUM_W-1:0] sum);
        if (sum > CREDIT_CAP)
            return CREDIT_CAP[CREDIT_W-1:0];
        return sum[CREDIT_W-1:0];
    endfunction

    // Acceptance is gated by reset too, so a word is never acked while state is being cleared.
    assign ack = user.vld_user2interface & (credits != '0) & ~resend & ~reset;
    assign user.ack_interface2user = ack;

    assign new_pkt = {1'b1, dst_leaf, dst_port, addr_ptr, user.din_leaf_user2interface};

    // Ack can never underflow the counter since it requires credits != 0.
    assign credit_sum = SUM_W'(credits)
                      + (freespace_update ? SUM_W'(FREESPACE_UPDATE_SIZE) : '0)
                      - SUM_W'(ack);

    always_ff @(posedge clk_user or posedge reset) begin
        if (reset) begin
            state                   <= ST_RUN;
            credits                 <= CREDIT_CAP[CREDIT_W-1:0];
            addr_ptr                <= '0;
            last_pkt                <= '0;
            last_vld                <= 1'b0;
            dout_leaf_interface2bft <= '0;
            credit_overflow         <= 1'b0;
        end else begin
            credits <= credit_sat(credit_sum);
            if (credit_sat_ovf(credit_sum))
                credit_overflow <= 1'b1;

            if (resend) begin
                // Back-to-back resends implies a packet was already re-issued, so last_pkt holds it.
                dout_leaf_interface2bft <= (last_vld || state == ST_RESEND) ? last_pkt : '0;
                state                   <= ST_RESEND;
            end else begin
                state <= ST_RUN;
                if (ack) begin
                    dout_leaf_interface2bft <= new_pkt;
                    last_pkt                <= new_pkt;
                    last_vld                <= 1'b1;
                    addr_ptr                <= addr_ptr + 1'b1;
                end else begin
                    dout_leaf_interface2bft <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Scoreboard bench for leaf_stream_packetizer: stimulus pushes expected packets, a
// negedge monitor pops and compares each valid packet the DUT emits.
module tb_leaf_stream_packetizer;
    logic        clk;
    logic        reset;
    logic [4:0]  dst_leaf;
    logic [3:0]  dst_port;
    logic        fu;
    logic        rs;
    logic [48:0] dout;
    logic        ovf;

    leaf_stream_packetizer_if #(.PAYLOAD_BITS(32)) uif ();

    leaf_stream_packetizer dut (
        .clk_user                (clk),
        .reset                   (reset),
        .user                    (uif),
        .dst_leaf                (dst_leaf),
        .dst_port                (dst_port),
        .freespace_update        (fu),
        .resend                  (rs),
        .dout_leaf_interface2bft (dout),
        .credit_overflow         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [48:0] expq[$];
    int          checks = 0;
    int          errors = 0;
    int          rx_cnt = 0;
    int          rx_base;
    logic [6:0]  exp_addr;
    logic [48:0] last_exp;
    logic        last_exp_vld;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid packet must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [48:0] e;
        if (!reset && dout[48]) begin
            rx_cnt++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pkt actual=%h expected=none at %0t", dout, $time);
            end else begin
                e = expq.pop_front();
                chk("pkt", 64'(dout), 64'(e));
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] d, input logic f, input logic r,
                        input logic exp_ack);
        logic [48:0] p;
        @(posedge clk);
        #1;
        uif.vld_user2interface      = v;
        uif.din_leaf_user2interface = d;
        fu = f;
        rs = r;
        #2;
        chk("ack", 64'(uif.ack_interface2user), 64'(exp_ack));
        if (r && last_exp_vld)
            expq.push_back(last_exp);
        if (exp_ack) begin
            p = {1'b1, dst_leaf, dst_port, exp_addr, d};
            expq.push_back(p);
            last_exp     = p;
            last_exp_vld = 1'b1;
            exp_addr     = exp_addr + 7'd1;
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; any in-flight packet is dropped.
    task automatic apply_reset(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk({tag, "_ack_in_reset"}, 64'(uif.ack_interface2user), 64'd0);
        chk({tag, "_dout_in_reset"}, 64'(dout), 64'd0);
        chk({tag, "_ovf_in_reset"}, 64'(ovf), 64'd0);
        expq.delete();
        exp_addr     = 7'd0;
        last_exp_vld = 1'b0;
        last_exp     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        uif.vld_user2interface = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        dst_leaf = 5'd3;
        dst_port = 4'd1;
        fu = 1'b0;
        rs = 1'b0;
        uif.vld_user2interface      = 1'b1;
        uif.din_leaf_user2interface = 32'h1234_5678;
        exp_addr     = 7'd0;
        last_exp     = '0;
        last_exp_vld = 1'b0;
        #2;
        chk("reset_ack", 64'(uif.ack_interface2user), 64'd0);
        chk("reset_dout", 64'(dout), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        uif.vld_user2interface = 1'b0;

        // Three words, addr 0..2.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'hA000_0000 + i, 1'b0, 1'b0, 1'b1);
        idle();
        idle();
        chk("first_three_rx", 64'(rx_cnt), 64'd3);

        // Hold vld: the remaining 125 credits drain, then ack stays low.
        for (int i = 0; i < 130; i++)
            step(1'b1, 32'hB000_0000 + i, 1'b0, 1'b0, (i < 125));
        idle();
        idle();
        chk("credit_exhaust_rx", 64'(rx_cnt), 64'd128);

        // One freespace update from zero credits: exactly 64 more, addr wraps to 0..63.
        step(1'b1, 32'hC000_0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 66; i++)
            step(1'b1, 32'hC000_0000 + i, 1'b0, 1'b0, (i < 64));
        idle();
        idle();
        chk("freespace_rx", 64'(rx_cnt), 64'd192);
        chk("freespace_ovf", 64'(ovf), 64'd0);

        // Reset mid-burst right after addr 10 is acked.
        apply_reset("init");
        rx_base = rx_cnt;
        for (int i = 0; i <= 10; i++)
            step(1'b1, 32'hE000_0000 + i, 1'b0, 1'b0, 1'b1);
        apply_reset("mid");
        chk("mid_burst_rx", 64'(rx_cnt - rx_base), 64'd10);

        // Resend with nothing sent yet yields no packet.
        rx_base = rx_cnt;
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();
        for (int i = 0; i <= 5; i++)
            step(1'b1, 32'hD000_0000 + i, 1'b0, 1'b0, 1'b1);
        // Two consecutive resends re-issue addr 5 twice, then addr 6 follows.
        step(1'b1, 32'hD000_0006, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hD000_0006, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hD000_0006, 1'b0, 1'b0, 1'b1);
        // Only 7 credits were used, so exactly 121 more words are accepted.
        for (int i = 0; i < 123; i++)
            step(1'b1, 32'hF000_0000 + i, 1'b0, 1'b0, (i < 121));
        idle();
        idle();
        chk("resend_rx", 64'(rx_cnt - rx_base), 64'd130);

        // Two updates bring credits to exactly 128 without overflow.
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("full_no_ovf", 64'(ovf), 64'd0);
        rx_base = rx_cnt;
        for (int i = 0; i < 28; i++)
            step(1'b1, 32'h5000_0000 + i, 1'b0, 1'b0, 1'b1);
        // Credits = 100; an update would give 164 and must clamp at 128.
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("clamp_ovf_set", 64'(ovf), 64'd1);
        for (int i = 0; i < 130; i++)
            step(1'b1, 32'h6000_0000 + i, 1'b0, 1'b0, (i < 128));
        idle();
        idle();
        chk("clamp_rx", 64'(rx_cnt - rx_base), 64'd156);
        chk("ovf_sticky", 64'(ovf), 64'd1);
        chk("queue_drained", 64'(expq.size()), 64'd0);

        apply_reset("final");
        chk("ovf_cleared", 64'(ovf), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
